// File: rtl/moving_avg_filter.sv
// moving_avg_filter: multi-channel boxcar (moving-average) filter over a
// power-of-two window. The window is preloaded with the first sample after
// reset or flush, and outputs are rounded half up and registered.
// Optional build macro MOVING_AVG_CHANGE_ONLY_EN rejects RUN-state samples
// that exactly repeat the last accepted vector.
module moving_avg_filter #(
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned LOG2_DEPTH = 2,
    parameter int unsigned CHANNELS   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      flush,
    output logic                      out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      primed
);

    localparam int unsigned DEPTH  = 1 << LOG2_DEPTH;
    localparam int unsigned SUM_W  = WIDTH + LOG2_DEPTH;
    localparam int unsigned FILL_W = LOG2_DEPTH + 1;
    localparam int unsigned VEC_W  = CHANNELS * WIDTH;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  state_q;
    logic [LOG2_DEPTH-1:0]   ptr_q,  ptr_d;
    logic [FILL_W-1:0]       fill_q, fill_d;
    logic [SUM_W-1:0]        sum_q   [CHANNELS];
    logic [SUM_W-1:0]        sum_d   [CHANNELS];
    logic [SUM_W-1:0]        round_c [CHANNELS];
    logic [WIDTH-1:0]        taps_q  [CHANNELS][DEPTH];
    logic [VEC_W-1:0]        out_data_q, out_data_d;
    logic                    out_valid_q;
    logic                    primed_q;
    logic                    accept_c;

`ifdef MOVING_AVG_CHANGE_ONLY_EN
    logic [VEC_W-1:0]        last_q;

    // Accept unless flushed, or a RUN-state sample repeats the last accepted vector.
    always_comb begin
        accept_c = in_valid & ~flush;
        if ((state_q == ST_RUN) && (in_data == last_q)) begin
            accept_c = 1'b0;
        end
    end
`else
    // Every valid sample is accepted unless a flush is requested.
    always_comb begin
        accept_c = in_valid & ~flush;
    end
`endif

    // Post-update running sums, rounded averages, pointer and fill count.
    always_comb begin
        out_data_d = out_data_q;
        ptr_d      = ptr_q;
        fill_d     = fill_q;
        for (int k = 0; k < CHANNELS; k++) begin
            sum_d[k]   = sum_q[k];
            round_c[k] = '0;
        end

        for (int k = 0; k < CHANNELS; k++) begin
            if (state_q == ST_EMPTY) begin
                sum_d[k] = SUM_W'(in_data[k*WIDTH +: WIDTH]) << LOG2_DEPTH;
            end else begin
                // Intermediate wrap is harmless: the true result always fits SUM_W.
                sum_d[k] = sum_q[k] + SUM_W'(in_data[k*WIDTH +: WIDTH])
                         - SUM_W'(taps_q[k][ptr_q]);
            end
            round_c[k] = sum_d[k] + SUM_W'(DEPTH / 2);
            out_data_d[k*WIDTH +: WIDTH] = WIDTH'(round_c[k] >> LOG2_DEPTH);
        end

        if (state_q == ST_EMPTY) begin
            ptr_d  = '0;
            fill_d = FILL_W'(1);
        end else begin
            ptr_d = ptr_q + LOG2_DEPTH'(1);
            if (fill_q != FILL_W'(DEPTH)) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    // State, window storage and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            ptr_q       <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            primed_q    <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                sum_q[k] <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    taps_q[k][d] <= '0;
                end
            end
`ifdef MOVING_AVG_CHANGE_ONLY_EN
            last_q      <= '0;
`endif
        end else if (flush) begin
            state_q     <= ST_EMPTY;
            fill_q      <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef MOVING_AVG_CHANGE_ONLY_EN
            last_q      <= '0;
`endif
        end else begin
            out_valid_q <= accept_c;
            if (accept_c) begin
                state_q    <= ST_RUN;
                ptr_q      <= ptr_d;
                fill_q     <= fill_d;
                primed_q   <= (fill_d == FILL_W'(DEPTH));
                out_data_q <= out_data_d;
                for (int k = 0; k < CHANNELS; k++) begin
                    sum_q[k] <= sum_d[k];
                    if (state_q == ST_EMPTY) begin
                        for (int d = 0; d < DEPTH; d++) begin
                            taps_q[k][d] <= in_data[k*WIDTH +: WIDTH];
                        end
                    end else begin
                        taps_q[k][ptr_q] <= in_data[k*WIDTH +: WIDTH];
                    end
                end
`ifdef MOVING_AVG_CHANGE_ONLY_EN
                last_q <= in_data;
`endif
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign primed    = primed_q;

endmodule
